freq_count_latch: RTL and testbench
===================================

Name: freq_count_latch

Overview:
- Measurement datapath driven by the frequency-meter state controller's clear/count_en/lock outputs.
- Times a fixed gate window in clk cycles and counts rising edges of an asynchronous input signal during that window.
- Signals gate completion back to the controller on cout_o.
- Latches the edge count as the frequency result when lock is asserted.

Parameters:
GATE_CYCLES, 1000000, gate window length in clk cycles (>=2)
CNT_W, 32, width of edge counter and result
SYNC_STAGES, 2, synchronizer flops on sig_i (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sig_i  input  1  measured signal, asynchronous to clk
clear_i  input  1  from controller: reset gate timer, edge counter, overflow accumulator
count_en_i  input  1  from controller: gate window open
lock_i  input  1  from controller: latch result
cout_o  output  1  gate done, registered level; feeds controller cout_i
freq_o  output  CNT_W  latched edge count of the last completed gate
freq_valid_o  output  1  one-cycle pulse when freq_o is updated
overflow_o  output  1  latched with freq_o: edge counter saturated in that gate

Behaviour:
- Reset (rst_n low, async): all flops 0, including the synchronizer chain, the edge-detect previous bit, gate_cnt, edge_cnt, ovf_acc, cout_o, freq_o, freq_valid_o and overflow_o.
- Synchronizer: sig_i passes through SYNC_STAGES flops. rise = sync_out & ~prev. rise is valid SYNC_STAGES+1 clk cycles after the sig_i edge. sig_i high at reset release yields one rise.
- Accepted cycle: count_en_i & ~cout_o & ~clear_i.
- Gate timer: gate_cnt, width clog2(GATE_CYCLES).
  - Increments on each accepted cycle.
  - On the accepted cycle where gate_cnt == GATE_CYCLES-1: cout_o <= 1, gate_cnt holds.
  - The window is exactly GATE_CYCLES accepted cycles.
- cout_o holds high until clear_i or reset. count_en_i staying high after cout_o is ignored, since the controller's outputs lag by one or more cycles.
- Pause: count_en_i low before gate done freezes gate_cnt and edge_cnt. Counting resumes where it left off.
- Edge counter: on an accepted cycle with rise, edge_cnt increments.
  - This includes the final accepted cycle.
  - At all-ones, edge_cnt holds and ovf_acc <= 1 (sticky).
- clear_i (priority over count_en_i): gate_cnt, edge_cnt, ovf_acc and cout_o <= 0. freq_o and overflow_o are unchanged.
- lock_i with cout_o high: freq_o <= edge_cnt, overflow_o <= ovf_acc, freq_valid_o <= 1 for one cycle.
  - lock_i with cout_o low is ignored: no update, no pulse.
  - lock_i held multiple cycles gives one pulse per cycle with the same value.
- lock_i and clear_i in the same cycle: the lock samples pre-clear values, and the clear takes effect the same edge.
- freq_o and overflow_o hold between locks.
- Reset mid-window: everything returns to 0, and the previous result is lost.
- Result units: edges per GATE_CYCLES clk periods. Scaling to Hz is done downstream.

Test Plan:
(GATE_CYCLES=100, CNT_W=8, SYNC_STAGES=2 unless noted)
- Reset: hold rst_n low with sig_i toggling -> all outputs 0. Release -> cout_o=0, freq_valid_o=0.
- Nominal gate: sig_i period 10 clk, pulse clear_i, count_en_i high 100 cycles -> cout_o rises after 100th accepted cycle. lock_i -> freq_o=10, overflow_o=0, one-cycle freq_valid_o.
- Trailing enable: count_en_i held 3 extra cycles after cout_o with sig_i toggling -> freq_o still 10. cout_o stays 1 until clear_i.
- Saturation: CNT_W=5, sig_i period 2 -> 50 edges clip, freq_o=31, overflow_o=1. Next gate at period 10 -> freq_o=10, overflow_o=0.
- Early lock and pause: lock_i at gate_cnt=40 -> no pulse, freq_o keeps old value. count_en_i low 20 cycles mid-window -> cout_o after 100 accepted cycles (120 wall cycles), count unaffected by edges during the pause.
- Reset mid-window and simultaneous events: rst_n low at gate_cnt=50 -> all 0. clear_i with lock_i when cout_o=1 -> freq_o takes the old edge_cnt, and the counters are 0 the next cycle.

Source files
------------

// File: rtl/freq_count_latch.sv
// Frequency-meter measurement datapath: times a gate window in clk cycles, counts
// synchronized rising edges of sig_i inside it and latches the count on lock.
module freq_count_latch #(
  parameter int unsigned GATE_CYCLES = 1000000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_i,
  input  logic             clear_i,
  input  logic             count_en_i,
  input  logic             lock_i,
  output logic             cout_o,
  output logic [CNT_W-1:0] freq_o,
  output logic             freq_valid_o,
  output logic             overflow_o
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [GATE_W-1:0]      gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   ovf_acc;

  logic [GATE_W-1:0]      gate_cnt_d;
  logic [CNT_W-1:0]       edge_cnt_d;
  logic                   ovf_acc_d;
  logic                   cout_d;
  logic [CNT_W-1:0]       freq_d;
  logic                   freq_valid_d;
  logic                   overflow_d;

  logic                   rise_c;
  logic                   accept_c;
  logic                   lock_c;

  // Metastability chain plus previous-sample flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c   = sync_q[SYNC_STAGES-1] & ~prev_q;
  // Enable arriving after gate done is a controller lag artefact and is ignored
  assign accept_c = count_en_i & ~cout_o & ~clear_i;
  assign lock_c   = lock_i & cout_o;

  // Next-state for gate timer, edge counter and result registers
  always_comb begin
    gate_cnt_d   = gate_cnt;
    edge_cnt_d   = edge_cnt;
    ovf_acc_d    = ovf_acc;
    cout_d       = cout_o;
    freq_d       = freq_o;
    freq_valid_d = 1'b0;
    overflow_d   = overflow_o;

    if (clear_i) begin
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      ovf_acc_d  = 1'b0;
      cout_d     = 1'b0;
    end else if (accept_c) begin
      if (gate_cnt == GATE_LAST) begin
        cout_d = 1'b1;
      end else begin
        gate_cnt_d = gate_cnt + GATE_W'(1);
      end
      if (rise_c) begin
        if (edge_cnt == CNT_MAX) begin
          ovf_acc_d = 1'b1;
        end else begin
          edge_cnt_d = edge_cnt + CNT_W'(1);
        end
      end
    end

    // Lock samples the pre-clear values when both arrive together
    if (lock_c) begin
      freq_d       = edge_cnt;
      overflow_d   = ovf_acc;
      freq_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      ovf_acc      <= 1'b0;
      cout_o       <= 1'b0;
      freq_o       <= '0;
      freq_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      gate_cnt     <= gate_cnt_d;
      edge_cnt     <= edge_cnt_d;
      ovf_acc      <= ovf_acc_d;
      cout_o       <= cout_d;
      freq_o       <= freq_d;
      freq_valid_o <= freq_valid_d;
      overflow_o   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_freq_count_latch.sv
// Self-checking bench for freq_count_latch: two instances (8-bit and 5-bit counters)
// share stimulus; a scoreboard queue per instance holds expected lock results.
module tb_freq_count_latch;

  logic       clk;
  logic       rst_n;
  logic       sig_i;
  logic       clear_i;
  logic       count_en_i;
  logic       lock_i;
  logic       cout8, valid8, ovf8;
  logic [7:0] freq8;
  logic       cout5, valid5, ovf5;
  logic [4:0] freq5;

  int errors = 0;
  int checks = 0;
  int sig_half = 5;
  int sig_cnt = 0;

  logic [8:0] q8[$];
  logic [5:0] q5[$];

  freq_count_latch #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sig_i(sig_i), .clear_i(clear_i),
    .count_en_i(count_en_i), .lock_i(lock_i), .cout_o(cout8),
    .freq_o(freq8), .freq_valid_o(valid8), .overflow_o(ovf8)
  );

  freq_count_latch #(.GATE_CYCLES(100), .CNT_W(5), .SYNC_STAGES(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .sig_i(sig_i), .clear_i(clear_i),
    .count_en_i(count_en_i), .lock_i(lock_i), .cout_o(cout5),
    .freq_o(freq5), .freq_valid_o(valid5), .overflow_o(ovf5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running square wave on sig_i, period 2*sig_half clk cycles
  initial begin
    sig_i = 1'b0;
    forever begin
      @(negedge clk);
      sig_cnt++;
      if (sig_cnt >= sig_half) begin
        sig_cnt = 0;
        sig_i = ~sig_i;
      end
    end
  end

  // Scoreboard: every result pulse must match the oldest expected entry
  initial begin
    logic [8:0] e8;
    logic [5:0] e5;
    forever begin
      @(negedge clk);
      if (valid8 === 1'b1) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL valid8_unexpected: got freq=%0d ovf=%0d, no result expected", freq8, ovf8);
        end else begin
          e8 = q8.pop_front();
          if ({ovf8, freq8} !== e8) begin
            errors++;
            $display("FAIL result8: got freq=%0d ovf=%0d, expected freq=%0d ovf=%0d",
                     freq8, ovf8, e8[7:0], e8[8]);
          end
        end
      end
      if (valid5 === 1'b1) begin
        checks++;
        if (q5.size() == 0) begin
          errors++;
          $display("FAIL valid5_unexpected: got freq=%0d ovf=%0d, no result expected", freq5, ovf5);
        end else begin
          e5 = q5.pop_front();
          if ({ovf5, freq5} !== e5) begin
            errors++;
            $display("FAIL result5: got freq=%0d ovf=%0d, expected freq=%0d ovf=%0d",
                     freq5, ovf5, e5[4:0], e5[5]);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_period(input int half);
    sig_half = half;
    step(20);
  endtask

  task automatic open_gate();
    @(negedge clk);
    clear_i = 1'b1;
    count_en_i = 1'b0;
    @(negedge clk);
    clear_i = 1'b0;
    count_en_i = 1'b1;
  endtask

  task automatic do_lock(input int n, input logic [7:0] f8, input logic o8,
                         input logic [4:0] f5, input logic o5);
    @(negedge clk);
    lock_i = 1'b1;
    q8.push_back({o8, f8});
    q5.push_back({o5, f5});
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      q8.push_back({o8, f8});
      q5.push_back({o5, f5});
    end
    @(negedge clk);
    lock_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 10; k++) begin
      if (q8.size() == 0 && q5.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (q8.size() != 0 || q5.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d/%0d results outstanding, expected 0", name, q8.size(), q5.size());
      q8.delete();
      q5.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(6);
    checks++;
    if ({cout8, valid8, ovf8, freq8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: got cout=%b valid=%b ovf=%b freq=%0d, expected all 0", cout8, valid8, ovf8, freq8);
    end
    checks++;
    if ({cout5, valid5, ovf5, freq5} !== 8'd0) begin
      errors++;
      $display("FAIL reset5: got cout=%b valid=%b ovf=%b freq=%0d, expected all 0", cout5, valid5, ovf5, freq5);
    end
    rst_n = 1'b1;
    step(3);
    checks++;
    if (cout8 !== 1'b0 || valid8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got cout=%b valid=%b, expected 0 0", cout8, valid8);
    end
  endtask

  task automatic test_nominal();
    set_period(5);
    open_gate();
    step(99);
    checks++;
    if (cout8 !== 1'b0) begin
      errors++;
      $display("FAIL nominal_cout_early: got %b after 99 accepted cycles, expected 0", cout8);
    end
    step(1);
    checks++;
    if (cout8 !== 1'b1) begin
      errors++;
      $display("FAIL nominal_cout: got %b after 100 accepted cycles, expected 1", cout8);
    end
    // Trailing enable while sig_i keeps toggling
    step(3);
    count_en_i = 1'b0;
    step(2);
    checks++;
    if (cout8 !== 1'b1) begin
      errors++;
      $display("FAIL trailing_cout: got %b, expected 1 until clear", cout8);
    end
    do_lock(1, 8'd10, 1'b0, 5'd10, 1'b0);
    step(1);
    checks++;
    if (valid8 !== 1'b0) begin
      errors++;
      $display("FAIL nominal_pulse_width: got valid=%b one cycle later, expected 0", valid8);
    end
    drain("nominal");
  endtask

  task automatic test_saturation();
    set_period(1);
    open_gate();
    step(100);
    count_en_i = 1'b0;
    do_lock(1, 8'd50, 1'b0, 5'd31, 1'b1);
    drain("saturation");
    set_period(5);
    open_gate();
    step(100);
    count_en_i = 1'b0;
    checks++;
    if (cout5 !== 1'b1) begin
      errors++;
      $display("FAIL sat_next_cout: got %b, expected 1", cout5);
    end
    do_lock(1, 8'd10, 1'b0, 5'd10, 1'b0);
    drain("sat_next");
  endtask

  task automatic test_back_to_back();
    do_lock(3, 8'd10, 1'b0, 5'd10, 1'b0);
    drain("back_to_back");
    checks++;
    if (cout8 !== 1'b1 || freq8 !== 8'd10) begin
      errors++;
      $display("FAIL b2b_hold: got cout=%b freq=%0d, expected 1 10", cout8, freq8);
    end
  endtask

  task automatic test_early_lock_pause();
    set_period(1);
    open_gate();
    step(40);
    lock_i = 1'b1;
    step(1);
    lock_i = 1'b0;
    checks++;
    if (valid8 !== 1'b0 || freq8 !== 8'd10) begin
      errors++;
      $display("FAIL early_lock: got valid=%b freq=%0d, expected 0 10", valid8, freq8);
    end
    step(9);
    count_en_i = 1'b0;
    step(20);
    count_en_i = 1'b1;
    step(49);
    checks++;
    if (cout8 !== 1'b0) begin
      errors++;
      $display("FAIL pause_cout_early: got %b after 99 accepted cycles, expected 0", cout8);
    end
    step(1);
    checks++;
    if (cout8 !== 1'b1) begin
      errors++;
      $display("FAIL pause_cout: got %b after 100 accepted cycles, expected 1", cout8);
    end
    count_en_i = 1'b0;
    do_lock(1, 8'd50, 1'b0, 5'd31, 1'b1);
    drain("pause");
  endtask

  task automatic test_clear_lock();
    set_period(5);
    open_gate();
    step(100);
    count_en_i = 1'b0;
    @(negedge clk);
    lock_i = 1'b1;
    clear_i = 1'b1;
    q8.push_back({1'b0, 8'd10});
    q5.push_back({1'b0, 5'd10});
    @(negedge clk);
    lock_i = 1'b0;
    clear_i = 1'b0;
    checks++;
    if (cout8 !== 1'b0 || dut.gate_cnt !== 7'd0 || dut.edge_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clear_lock_counters: got cout=%b gate=%0d edge=%0d, expected 0 0 0",
               cout8, dut.gate_cnt, dut.edge_cnt);
    end
    drain("clear_lock");
  endtask

  task automatic test_reset_mid();
    set_period(1);
    open_gate();
    step(100);
    count_en_i = 1'b0;
    do_lock(1, 8'd50, 1'b0, 5'd31, 1'b1);
    drain("pre_reset");
    open_gate();
    step(50);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cout8, valid8, ovf8, freq8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid8: got cout=%b valid=%b ovf=%b freq=%0d, expected all 0", cout8, valid8, ovf8, freq8);
    end
    checks++;
    if ({cout5, ovf5, freq5} !== 7'd0 || dut.gate_cnt !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid5: got cout=%b ovf=%b freq=%0d gate=%0d, expected all 0",
               cout5, ovf5, freq5, dut.gate_cnt);
    end
    count_en_i = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_i = 1'b0;
    count_en_i = 1'b0;
    lock_i = 1'b0;
    test_reset();
    test_nominal();
    test_saturation();
    test_back_to_back();
    test_early_lock_pause();
    test_clear_lock();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
